// File: rtl/router_pkg.sv
// Shared definitions for the router input-port-0 encapsulator: header field
// offsets, header-flit field positions and encapsulator FSM state codes.
// The TRAILER state code exists only when PKT_ENCAP_CHECKSUM_EN is defined.
package router_pkg;

    // 9-bit header: {TTL, pkt_num, src_router}
    localparam int HDR_W      = 9;
    localparam int TTL_MSB    = 8;
    localparam int TTL_LSB    = 7;
    localparam int PKTNUM_MSB = 6;
    localparam int PKTNUM_LSB = 2;
    localparam int SRC_MSB    = 1;
    localparam int SRC_LSB    = 0;

    // Header flit layout: header at bit 0, destination address right above it,
    // then an 8-bit payload length; the remaining upper bits are zero.
    localparam int HDR_LSB = 0;
    localparam int DST_LSB = HDR_W;
    localparam int LEN_W   = 8;

    // Encapsulator FSM states
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_HEAD    = 3'd1;
    localparam logic [2:0] ST_PAYLOAD = 3'd2;
`ifdef PKT_ENCAP_CHECKSUM_EN
    localparam logic [2:0] ST_TRAILER = 3'd3;
`endif
    localparam logic [2:0] ST_DONE    = 3'd4;

endpackage

// File: rtl/pkt_xor_checksum.sv
// Running XOR of payload words. Cleared while the encapsulator sends the
// header, so no reset is needed: the value is always re-initialised before use.
module pkt_xor_checksum #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] accum
);

    // Accumulate every enabled word; clear takes priority.
    always_ff @(posedge clk) begin
        if (clear) begin
            accum <= '0;
        end else if (enable) begin
            accum <= accum ^ data;
        end
    end

endmodule

// File: rtl/pkt_encap.sv
// Packet encapsulator for router input port 0. On an accepted start it writes
// one header flit followed by PAYLOAD_WORDS payload flits from the granted
// source into the port FIFO, then pulses encap_done.
// Optional build macro PKT_ENCAP_CHECKSUM_EN: appends one trailer flit holding
// the XOR of all payload words before encap_done.
module pkt_encap
    import router_pkg::*;
#(
    parameter int AURORA_DATA_WIDTH = 64,
    parameter int ADDR_WIDTH        = 10,
    parameter int PAYLOAD_WORDS     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_encap_pkt,
    input  logic [ADDR_WIDTH-1:0]        router_dst_addr_send,
    input  logic [8:0]                   header_pkt_send,
    output logic                         encap_done,
    output logic                         encap_busy,
    input  logic [AURORA_DATA_WIDTH-1:0] src_data,
    input  logic                         src_valid,
    output logic                         src_ready,
    output logic [AURORA_DATA_WIDTH-1:0] fifo_wdata,
    output logic                         fifo_we,
    input  logic                         fifo_full
);

    localparam int CNT_W   = $clog2(PAYLOAD_WORDS + 1);
    localparam int LEN_LSB = DST_LSB + ADDR_WIDTH;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PAYLOAD_WORDS - 1);

    logic [2:0]                   state;
    logic [CNT_W-1:0]             cnt;
    logic [HDR_W-1:0]             hdr_q;
    logic [ADDR_WIDTH-1:0]        dst_q;
    logic [AURORA_DATA_WIDTH-1:0] head_flit;
    logic                         pay_wr;
    logic                         last_wr;

    assign pay_wr  = (state == ST_PAYLOAD) && src_valid && !fifo_full;
    // Terminal count is checked on the write itself, so the counter never wraps.
    assign last_wr = pay_wr && (cnt == LAST_CNT);

`ifdef PKT_ENCAP_CHECKSUM_EN
    logic [AURORA_DATA_WIDTH-1:0] csum;

    pkt_xor_checksum #(
        .WIDTH (AURORA_DATA_WIDTH)
    ) u_csum (
        .clk    (clk),
        .clear  (state == ST_HEAD),
        .enable (pay_wr),
        .data   (src_data),
        .accum  (csum)
    );
`endif

    // Assemble the header flit from the fields latched at accept.
    always_comb begin
        head_flit = '0;
        head_flit[HDR_LSB+HDR_W-1:HDR_LSB] = hdr_q;
        head_flit[LEN_LSB-1:DST_LSB]       = dst_q;
        head_flit[LEN_LSB+LEN_W-1:LEN_LSB] = LEN_W'(PAYLOAD_WORDS);
    end

    // FSM, payload counter and latched header/address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            hdr_q <= '0;
            dst_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_encap_pkt) begin
                        hdr_q <= header_pkt_send;
                        dst_q <= router_dst_addr_send;
                        cnt   <= '0;
                        state <= ST_HEAD;
                    end
                end
                ST_HEAD: begin
                    if (!fifo_full) begin
                        state <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (pay_wr) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (last_wr) begin
`ifdef PKT_ENCAP_CHECKSUM_EN
                        state <= ST_TRAILER;
`else
                        state <= ST_DONE;
`endif
                    end
                end
`ifdef PKT_ENCAP_CHECKSUM_EN
                ST_TRAILER: begin
                    if (!fifo_full) begin
                        state <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // FIFO write path and source handshake, decoded from state and back-pressure.
    always_comb begin
        fifo_we    = 1'b0;
        fifo_wdata = '0;
        src_ready  = 1'b0;
        case (state)
            ST_HEAD: begin
                fifo_we    = !fifo_full;
                fifo_wdata = head_flit;
            end
            ST_PAYLOAD: begin
                src_ready  = !fifo_full;
                fifo_we    = pay_wr;
                fifo_wdata = pay_wr ? src_data : '0;
            end
`ifdef PKT_ENCAP_CHECKSUM_EN
            ST_TRAILER: begin
                fifo_we    = !fifo_full;
                fifo_wdata = csum;
            end
`endif
            default: begin
                fifo_we    = 1'b0;
            end
        endcase
    end

    assign encap_done = (state == ST_DONE);
    assign encap_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_pkt_encap.sv
// Scoreboard bench for pkt_encap: expected flits are queued when a packet is
// launched and compared as the DUT writes its FIFO. Timing is measured in
// cycles relative to the accept cycle. Honours PKT_ENCAP_CHECKSUM_EN.
module tb_pkt_encap;

`ifdef PKT_ENCAP_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif
    localparam int NPAY  = 16;
    localparam int NFLIT = NPAY + 1 + CK;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_encap_pkt = 1'b0;
    logic [9:0]  router_dst_addr_send = '0;
    logic [8:0]  header_pkt_send = '0;
    logic        encap_done;
    logic        encap_busy;
    logic [63:0] src_data;
    logic        src_valid = 1'b0;
    logic        src_ready;
    logic [63:0] fifo_wdata;
    logic        fifo_we;
    logic        fifo_full = 1'b0;

    logic [63:0] exp_q[$];
    logic [63:0] src_base = '0;
    logic [63:0] first_flit = '0;
    int          src_idx = 0;
    int          cyc = 0;
    int          t0 = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          done_rel = -1;
    int          total = 0;
    int          bad = 0;

    pkt_encap #(
        .AURORA_DATA_WIDTH (64),
        .ADDR_WIDTH        (10),
        .PAYLOAD_WORDS     (NPAY)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start_encap_pkt      (start_encap_pkt),
        .router_dst_addr_send (router_dst_addr_send),
        .header_pkt_send      (header_pkt_send),
        .encap_done           (encap_done),
        .encap_busy           (encap_busy),
        .src_data             (src_data),
        .src_valid            (src_valid),
        .src_ready            (src_ready),
        .fifo_wdata           (fifo_wdata),
        .fifo_we              (fifo_we),
        .fifo_full            (fifo_full)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Source model: sequence base, base+1, ... restarted on each accepted start.
    assign src_data = src_base + 64'(src_idx);
    always @(posedge clk) begin
        if (start_encap_pkt && !encap_busy) src_idx <= 0;
        else if (src_valid && src_ready) src_idx <= src_idx + 1;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // FIFO-side monitor: scoreboard pops and done-pulse timing.
    always @(negedge clk) begin
        if (fifo_we) begin
            check_val("we_while_full", 64'(fifo_full), 64'd0);
            if (exp_q.size() == 0) check_val("unexpected_write", 64'(exp_q.size()), 64'd1);
            else check_val("flit", fifo_wdata, exp_q.pop_front());
            if (wr_cnt == 0) first_flit = fifo_wdata;
            wr_cnt++;
        end
        if (encap_done) begin
            done_cnt++;
            done_rel = cyc - t0;
        end
    end

    function automatic logic [63:0] hdr_flit(input logic [8:0] h, input logic [9:0] d);
        return {37'd0, 8'(NPAY), d, h};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pkt(input logic [8:0] h, input logic [9:0] d, input logic [63:0] base);
        logic [63:0] x;
        x = '0;
        exp_q.push_back(hdr_flit(h, d));
        for (int i = 0; i < NPAY; i++) begin
            exp_q.push_back(base + 64'(i));
            x = x ^ (base + 64'(i));
        end
        if (CK == 1) exp_q.push_back(x);
        src_base = base;
        wr_cnt   = 0;
        done_cnt = 0;
        done_rel = -1;
    endtask

    // mode 1: clean, 2: fifo_full stalls, 3: src_valid toggling, 4: extra starts
    task automatic run_pkt(input logic [8:0] h, input logic [9:0] d, input logic [63:0] base,
                           input int mode, input int exp_done);
        push_pkt(h, d, base);
        for (int c = 0; c <= exp_done + 4; c++) begin
            start_encap_pkt      = (c == 0) || (mode == 4 && (c == 5 || c == exp_done));
            header_pkt_send      = (c == 0) ? h : 9'h0AA;
            router_dst_addr_send = (c == 0) ? d : 10'h155;
            fifo_full            = (mode == 2) && ((c >= 1 && c <= 3) || c == 10 || c == 11);
            src_valid            = (mode == 3) ? (c % 2 == 0) : 1'b1;
            if (c == 0) t0 = cyc;
            tick();
        end
        start_encap_pkt = 1'b0;
        fifo_full       = 1'b0;
        src_valid       = 1'b0;
        check_val("done_count", 64'(done_cnt), 64'd1);
        check_val("done_cycle", 64'(done_rel), 64'(exp_done));
        check_val("flit_count", 64'(wr_cnt), 64'(NFLIT));
        check_val("leftover", 64'(exp_q.size()), 64'd0);
        check_val("busy_after", 64'(encap_busy), 64'd0);
    endtask

    initial begin
        repeat (3) tick();
        check_val("rst_busy", 64'(encap_busy), 64'd0);
        check_val("rst_done", 64'(encap_done), 64'd0);
        check_val("rst_we", 64'(fifo_we), 64'd0);
        check_val("rst_ready", 64'(src_ready), 64'd0);
        check_val("rst_wdata", fifo_wdata, 64'd0);
        rst = 1'b0;
        tick();

        // 1: clean packet, payload 1..16
        run_pkt(9'h105, 10'h2A3, 64'd1, 1, 18 + CK);
        check_val("hdr_field", 64'(first_flit[8:0]), 64'h105);
        check_val("dst_field", 64'(first_flit[18:9]), 64'h2A3);
        check_val("len_field", 64'(first_flit[26:19]), 64'd16);
        check_val("hdr_upper", 64'(first_flit[63:27]), 64'd0);

        // 2: FIFO back-pressure in HEAD and mid-payload
        run_pkt(9'h0C3, 10'h3FF, 64'hA000, 2, 23 + CK);

        // 3: source valid on alternate cycles
        run_pkt(9'h1E2, 10'h001, 64'hDEAD_0000, 3, 33 + CK);

        // 4: starts during PAYLOAD and DONE must be ignored
        run_pkt(9'h105, 10'h2A3, 64'd100, 4, 18 + CK);
        check_val("hdr_kept", first_flit, hdr_flit(9'h105, 10'h2A3));

        // 5: reset right after the 5th payload write
        push_pkt(9'h07F, 10'h001, 64'd500);
        for (int c = 0; c <= 7; c++) begin
            start_encap_pkt      = (c == 0);
            header_pkt_send      = 9'h07F;
            router_dst_addr_send = 10'h001;
            src_valid            = (c < 7);
            rst                  = (c == 7);
            if (c == 0) t0 = cyc;
            tick();
        end
        rst = 1'b0;
        start_encap_pkt = 1'b0;
        src_valid = 1'b1;
        check_val("mid_rst_busy", 64'(encap_busy), 64'd0);
        check_val("mid_rst_done", 64'(encap_done), 64'd0);
        check_val("mid_rst_we", 64'(fifo_we), 64'd0);
        check_val("mid_rst_ready", 64'(src_ready), 64'd0);
        check_val("mid_rst_wdata", fifo_wdata, 64'd0);
        check_val("mid_rst_writes", 64'(wr_cnt), 64'd6);
        check_val("mid_rst_no_done", 64'(done_cnt), 64'd0);
        exp_q.delete();
        src_valid = 1'b0;
        repeat (2) tick();
        run_pkt(9'h111, 10'h222, 64'd7, 1, 18 + CK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
